l2_dram_line_adapter: RTL and testbench

Downstream neighbour of the L2 cache. It converts the L2's 256-bit single-transfer memory port (`dfp_*`) into the 64-bit, 4-beat burst protocol of the banked DRAM model (`bmem_*`). It serialises write-backs into beats and reassembles read bursts into a full cacheline. It has one outstanding transaction and a registered line buffer, and it asserts `dfp_resp` once the whole line has moved.

---
 rtl/l2_dram_line_adapter.sv | 137 +++++++++++++
 tb/tb_l2_dram_line_adapter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_dram_line_adapter.sv
// L2 <-> banked DRAM line adapter.
// Turns one 256-bit L2 line transfer into a 4-beat 64-bit DRAM burst (write-back)
// or collects a 4-beat DRAM read burst into a full line. One transaction in flight.
//
// Handshake rules used throughout:
//   dfp side : dfp_read/dfp_write are level requests, sampled only in IDLE and held
//              by the L2 until the single-cycle dfp_resp pulse.
//   bmem side: a command or write beat is presented (bmem_read/bmem_write high) and
//              stays stable until a cycle with bmem_ready high, which consumes it.
//              Read beats arrive with bmem_rvalid (no back-pressure) and are kept only
//              while waiting for data and only when bmem_raddr matches the burst.
module l2_dram_line_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [31:0]           bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [31:0]           bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid,
    output logic [2:0]            dbg_state
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(BEATS - 1);
    // Clears the byte-offset bits of a line address (bits [4:0] for 32-byte lines).
    localparam logic [31:0] ALIGN_MASK = ~32'(LINE_WIDTH / 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ_REQ  = 3'd2,
        S_READ_WAIT = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t                state;
    logic [CW-1:0]         k;
    logic [CW-1:0]         k_inc;
    logic [31:0]           addr_q;
    logic [LINE_WIDTH-1:0] wline_q;
    logic [LINE_WIDTH-1:0] rline_q;

    // Next beat index; only used where k < K_LAST, so wrap is never observed.
    assign k_inc     = k + 1'b1;
    assign bmem_addr = addr_q;
    assign dfp_rdata = rline_q;
    assign dbg_state = state;

    // Transaction FSM: all outputs are registered so bmem_* never depends on dfp_* combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            k          <= '0;
            addr_q     <= '0;
            wline_q    <= '0;
            rline_q    <= '0;
            dfp_resp   <= 1'b0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    k <= '0;
                    // Write-back wins over a simultaneous read; the read stays asserted
                    // and is picked up in a later IDLE cycle.
                    if (dfp_write) begin
                        addr_q     <= dfp_addr & ALIGN_MASK;
                        wline_q    <= dfp_wdata;
                        bmem_wdata <= dfp_wdata[BEAT_WIDTH-1:0];
                        bmem_write <= 1'b1;
                        state      <= S_WRITE;
                    end else if (dfp_read) begin
                        addr_q    <= dfp_addr & ALIGN_MASK;
                        bmem_read <= 1'b1;
                        state     <= S_READ_REQ;
                    end
                end
                S_WRITE: begin
                    // Current beat is held until the DRAM takes it.
                    if (bmem_ready) begin
                        if (k == K_LAST) begin
                            k          <= '0;
                            bmem_write <= 1'b0;
                            bmem_wdata <= '0;
                            dfp_resp   <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            k          <= k_inc;
                            bmem_wdata <= wline_q[k_inc*BEAT_WIDTH +: BEAT_WIDTH];
                        end
                    end
                end
                S_READ_REQ: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        state     <= S_READ_WAIT;
                    end
                end
                S_READ_WAIT: begin
                    // Beats arrive in ascending order; beat 0 lands in the LSBs.
                    if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                        rline_q[k*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
                        if (k == K_LAST) begin
                            k        <= '0;
                            dfp_resp <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            k <= k_inc;
                        end
                    end
                end
                S_RESP: begin
                    dfp_resp <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_dram_line_adapter.sv
// Directed bench for l2_dram_line_adapter: transaction-level model (expected beat and
// response queues) checked every cycle, plus literal timing/data expectations.
module tb_l2_dram_line_adapter;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [31:0]  dfp_addr = '0;
    logic         dfp_read = 1'b0;
    logic         dfp_write = 1'b0;
    logic [255:0] dfp_wdata = '0;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready = 1'b1;
    logic [31:0]  bmem_raddr = '0;
    logic [63:0]  bmem_rdata = '0;
    logic         bmem_rvalid = 1'b0;
    logic [2:0]   dbg_state;

    l2_dram_line_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0]  exp_beat_q[$];   // write beats the DRAM must see, in order
    logic [255:0] exp_line_q[$];   // dfp_rdata expected at each dfp_resp, in order
    logic [31:0]  exp_addr = '0;
    logic [255:0] model_rdata = '0;

    // Per-transaction stimulus schedule, indexed by cycle offset from the request cycle.
    int           rv_kind[64];     // 0 none, 1 real beat, 2 stray address, 3 matching addr but too early/late
    logic [63:0]  rv_data[64];
    int           lo_from = -1;
    int           lo_to   = -1;

    // Per-transaction observations.
    int           first_rd, first_wr, rd_cycles, nresp;
    int           resp_at[2];
    logic [31:0]  rd_addr_seen, wr_addr_seen;
    logic [63:0]  wbeat_at[64];
    bit           wr_at[64];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of DUT outputs against the transaction model.
    always @(negedge clk) begin
        if (rst) begin
            if (bmem_read || bmem_write)
                check("bmem_rw_exclusive", {255'd0, bmem_read & bmem_write}, 256'd0);
            if (bmem_write) begin
                if (exp_beat_q.size() == 0) begin
                    check("bmem_write_unexpected", {255'd0, bmem_write}, 256'd0);
                end else begin
                    check("bmem_wdata", {192'd0, bmem_wdata}, {192'd0, exp_beat_q[0]});
                    check("bmem_addr_wr", {224'd0, bmem_addr}, {224'd0, exp_addr});
                    if (bmem_ready) void'(exp_beat_q.pop_front());
                end
            end
            if (bmem_read)
                check("bmem_addr_rd", {224'd0, bmem_addr}, {224'd0, exp_addr});
            if (dfp_resp) begin
                if (exp_line_q.size() == 0) begin
                    check("dfp_resp_unexpected", {255'd0, dfp_resp}, 256'd0);
                end else begin
                    check("dfp_rdata_at_resp", dfp_rdata, exp_line_q[0]);
                    void'(exp_line_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_sched();
        for (int i = 0; i < 64; i++) begin
            rv_kind[i]  = 0;
            rv_data[i]  = '0;
            wbeat_at[i] = '0;
            wr_at[i]    = 1'b0;
        end
        lo_from = -1;
        lo_to   = -1;
    endtask

    task automatic drive_rv(input int off);
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        if (off >= 0 && off < 64) begin
            case (rv_kind[off])
                1: begin bmem_rvalid = 1'b1; bmem_raddr = exp_addr; bmem_rdata = rv_data[off]; end
                2: begin bmem_rvalid = 1'b1; bmem_raddr = exp_addr + 32'h20; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0; end
                3: begin bmem_rvalid = 1'b1; bmem_raddr = exp_addr; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF; end
                default: ;
            endcase
        end
    endtask

    // Issues a request (write, read or both) and runs until every expected response arrives.
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [255:0] wline, input int max_cyc);
        int t0, off, want, b;
        logic [255:0] l;
        exp_addr = addr & 32'hFFFF_FFE0;
        if (wr) begin
            for (int i = 0; i < 4; i++) exp_beat_q.push_back(wline[64*i +: 64]);
            exp_line_q.push_back(model_rdata);
        end
        if (rd) begin
            l = '0;
            b = 0;
            for (int i = 0; i < 64; i++)
                if (rv_kind[i] == 1 && b < 4) begin
                    l[64*b +: 64] = rv_data[i];
                    b++;
                end
            model_rdata = l;
            exp_line_q.push_back(l);
        end
        want = int'(wr) + int'(rd);
        first_rd = -1; first_wr = -1; rd_cycles = 0; nresp = 0;
        resp_at[0] = -1; resp_at[1] = -1;
        rd_addr_seen = '0; wr_addr_seen = '0;

        @(posedge clk); #1;
        t0 = cyc;
        dfp_addr    = addr;
        dfp_wdata   = wline;
        dfp_write   = wr;
        dfp_read    = rd;
        bmem_ready  = 1'b1;
        bmem_rvalid = 1'b0;
        for (int n = 0; n < max_cyc && nresp < want; n++) begin
            bit got;
            got = 1'b0;
            @(negedge clk);
            off = cyc - t0;
            if (bmem_read) begin
                rd_cycles++;
                if (first_rd < 0) begin first_rd = off; rd_addr_seen = bmem_addr; end
            end
            if (bmem_write && first_wr < 0) begin first_wr = off; wr_addr_seen = bmem_addr; end
            if (off < 64) begin wbeat_at[off] = bmem_wdata; wr_at[off] = bmem_write; end
            if (dfp_resp) begin
                if (nresp < 2) resp_at[nresp] = off;
                nresp++;
                got = 1'b1;
            end
            @(posedge clk); #1;
            off = cyc - t0;
            if (got) begin
                if (dfp_write) dfp_write = 1'b0;
                else           dfp_read  = 1'b0;
            end
            bmem_ready = !(off >= lo_from && off <= lo_to);
            drive_rv(off);
        end
        check("txn_resp_count", 256'(nresp), 256'(want));
        dfp_write   = 1'b0;
        dfp_read    = 1'b0;
        bmem_ready  = 1'b1;
        bmem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("write_beats_left", 256'(exp_beat_q.size()), 256'd0);
        check("resp_left", 256'(exp_line_q.size()), 256'd0);
    endtask

    // ---------------- directed tests ----------------
    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
                                       64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};

    initial begin
        int act, t0;
        logic [255:0] rd_line;

        // Reset then idle.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_dfp_resp",   {255'd0, dfp_resp},   256'd0);
        check("rst_dfp_rdata",  dfp_rdata,            256'd0);
        check("rst_bmem_read",  {255'd0, bmem_read},  256'd0);
        check("rst_bmem_write", {255'd0, bmem_write}, 256'd0);
        check("rst_bmem_addr",  {224'd0, bmem_addr},  256'd0);
        check("rst_bmem_wdata", {192'd0, bmem_wdata}, 256'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bmem_read || bmem_write || dfp_resp) act++;
        end
        check("idle_activity", 256'(act), 256'd0);

        // Write, ready tied high.
        clear_sched();
        run_txn(1'b1, 1'b0, 32'h0000_1234, LINE_A, 30);
        check("wr_addr_aligned", {224'd0, wr_addr_seen}, {224'd0, 32'h0000_1220});
        check("wr_first_beat_cycle", 256'(first_wr), 256'd1);
        check("wr_beat0", {192'd0, wbeat_at[1]}, {192'd0, 64'h1111_1111_1111_1111});
        check("wr_beat1", {192'd0, wbeat_at[2]}, {192'd0, 64'h2222_2222_2222_2222});
        check("wr_beat2", {192'd0, wbeat_at[3]}, {192'd0, 64'h3333_3333_3333_3333});
        check("wr_beat3", {192'd0, wbeat_at[4]}, {192'd0, 64'h4444_4444_4444_4444});
        check("wr_resp_cycle", 256'(resp_at[0]), 256'd5);
        check("wr_rdata_untouched", dfp_rdata, 256'd0);

        // Write with bmem_ready low in cycles 2-3.
        clear_sched();
        lo_from = 2;
        lo_to   = 3;
        run_txn(1'b1, 1'b0, 32'h0000_2000, LINE_B, 30);
        act = 0;
        for (int i = 0; i < 64; i++)
            if (wr_at[i] && wbeat_at[i] == 64'hB1B1_0000_0000_0001) act++;
        check("wr_stall_beat1_held", 256'(act), 256'd3);
        check("wr_stall_resp_cycle", 256'(resp_at[0]), 256'd7);

        // Read 0x8000_0040: early matching beat while still requesting, 2-cycle gap
        // with a stray-address beat inside it.
        clear_sched();
        rv_kind[1] = 3;
        rv_kind[2] = 1; rv_data[2] = 64'h0123_4567_89AB_CDEF;
        rv_kind[3] = 1; rv_data[3] = 64'hFEDC_BA98_7654_3210;
        rv_kind[4] = 2;
        rv_kind[6] = 1; rv_data[6] = 64'h0F0F_0F0F_F0F0_F0F0;
        rv_kind[7] = 1; rv_data[7] = 64'h5555_AAAA_5555_AAAA;
        run_txn(1'b0, 1'b1, 32'h8000_0040, 256'd0, 30);
        rd_line = {64'h5555_AAAA_5555_AAAA, 64'h0F0F_0F0F_F0F0_F0F0,
                   64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        check("rd_first_cmd_cycle", 256'(first_rd), 256'd1);
        check("rd_addr", {224'd0, rd_addr_seen}, {224'd0, 32'h8000_0040});
        check("rd_resp_cycle", 256'(resp_at[0]), 256'd8);
        check("rd_line", dfp_rdata, rd_line);

        // Read with unaligned address and a stalled command.
        clear_sched();
        lo_from = 1;
        lo_to   = 2;
        for (int i = 4; i < 8; i++) begin
            rv_kind[i] = 1;
            rv_data[i] = 64'hC000_0000_0000_0000 | 64'(i);
        end
        run_txn(1'b0, 1'b1, 32'h8000_0047, 256'd0, 30);
        check("rd2_addr", {224'd0, rd_addr_seen}, {224'd0, 32'h8000_0040});
        check("rd2_cmd_cycles", 256'(rd_cycles), 256'd3);
        check("rd2_resp_cycle", 256'(resp_at[0]), 256'd8);
        check("rd2_line", dfp_rdata, {64'hC000_0000_0000_0007, 64'hC000_0000_0000_0006,
                                      64'hC000_0000_0000_0005, 64'hC000_0000_0000_0004});

        // Read and write together: write first, read after RESP plus one IDLE cycle.
        clear_sched();
        rv_kind[3] = 3;
        for (int i = 8; i < 12; i++) begin
            rv_kind[i] = 1;
            rv_data[i] = 64'hD000_0000_0000_0010 + 64'(i);
        end
        run_txn(1'b1, 1'b1, 32'h0000_0100, LINE_A, 40);
        check("both_first_wr", 256'(first_wr), 256'd1);
        check("both_wr_resp", 256'(resp_at[0]), 256'd5);
        check("both_first_rd", 256'(first_rd), 256'd7);
        check("both_rd_resp", 256'(resp_at[1]), 256'd12);
        check("both_rd_line", dfp_rdata, {64'hD000_0000_0000_001B, 64'hD000_0000_0000_001A,
                                          64'hD000_0000_0000_0019, 64'hD000_0000_0000_0018});

        // Reset during write beat 2: outputs drop at once, no response follows.
        clear_sched();
        exp_addr = 32'h0000_0300;
        for (int i = 0; i < 4; i++) exp_beat_q.push_back(LINE_B[64*i +: 64]);
        @(posedge clk); #1;
        t0 = cyc;
        dfp_addr  = 32'h0000_0300;
        dfp_wdata = LINE_B;
        dfp_write = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("abort_cycle", 256'(cyc - t0), 256'd3);
        check("abort_pre_beat2", {192'd0, bmem_wdata}, {192'd0, 64'hB2B2_0000_0000_0002});
        rst = 1'b0;
        #1;
        check("abort_bmem_write", {255'd0, bmem_write}, 256'd0);
        check("abort_bmem_wdata", {192'd0, bmem_wdata}, 256'd0);
        check("abort_bmem_addr",  {224'd0, bmem_addr},  256'd0);
        check("abort_dfp_rdata",  dfp_rdata,            256'd0);
        check("abort_dfp_resp",   {255'd0, dfp_resp},   256'd0);
        dfp_write = 1'b0;
        exp_beat_q.delete();
        exp_line_q.delete();
        model_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dfp_resp || bmem_write || bmem_read) act++;
        end
        check("abort_no_resp", 256'(act), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
